// File: rtl/regfile_scan_if.sv
// Signal bundle between the scan sequencer, its controller, the regfile and the dump sink.
// Stream handshake: a beat transfers on a rising edge where out_valid & out_ready are both high.
interface regfile_scan_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] fill_base;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;
  logic              regwrite;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  start, mode, fill_base, rd, out_ready,
    output busy, done, ra, regwrite, wa, wd, out_valid, out_addr, out_data
  );

  modport master (
    output start, mode, fill_base, rd, out_ready,
    input  busy, done, ra, regwrite, wa, wd, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/regfile_scan.sv
// Regfile scan sequencer: FILL writes base+idx to every register, DUMP streams (addr, data).
// All outputs decode from registered state, so async reset clears them immediately.
module regfile_scan #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_scan_if.slave     bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_RD   = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      base_q     <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      base_q     <= base_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    base_d     = base_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          base_d  = bus.fill_base;
          state_d = bus.mode ? S_FILL : S_RD;
        end
      end
      S_FILL: begin
        if (idx == LAST) state_d = S_DONE;
        else             idx_d   = idx + 1'b1;
      end
      S_RD: begin
        // Regfile read is combinational, so rd already reflects ra=idx here.
        out_addr_d = idx;
        out_data_d = bus.rd;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (bus.out_ready) begin
          if (idx == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx + 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.done      = 1'b0;
    bus.ra        = '0;
    bus.regwrite  = 1'b0;
    bus.wa        = '0;
    bus.wd        = '0;
    bus.out_valid = 1'b0;
    bus.out_addr  = out_addr_q;
    bus.out_data  = out_data_q;
    case (state)
      S_FILL: begin
        bus.regwrite = 1'b1;
        bus.wa       = idx;
        bus.wd       = base_q + DATA_W'(idx);
      end
      S_RD:    bus.ra        = idx;
      S_SEND:  bus.out_valid = 1'b1;
      S_DONE:  bus.done      = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule
